// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store initiator for a word-only data memory; sub-word stores use read-modify-write.
// Optional feature: define MAC_ALIGN_CHECK_EN to report misaligned requests through err.
module mem_access_ctrl #(
  parameter logic [31:0] INIT_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_t;
  state_t state, state_nx;
  logic        r_we, r_sext, fin, accept, mis;
  logic [1:0]  r_size;
  logic [31:0] a, a_in, r_wdata, r_pc, merge;
  logic        is_word, is_half, sub_store;
  logic [4:0]  sh;
  logic [31:0] shifted, load_val, mask, ins, merged;
  logic [15:0] half16;
  logic [7:0]  byte8;
  assign accept = req & ready;
`ifdef MAC_ALIGN_CHECK_EN
  assign mis  = (size == 2'd1 & addr[0]) | (size[1] & |addr[1:0]);
  assign a_in = addr;
`else
  // Without the check, misaligned addresses are forced down to natural alignment.
  assign mis  = 1'b0;
  assign a_in = size[1] ? {addr[31:2], 2'b00} : size[0] ? {addr[31:1], 1'b0} : addr;
`endif
  // Size 3 is reserved and behaves as a word.
  assign is_word   = r_size[1];
  assign is_half   = r_size == 2'd1;
  assign sub_store = r_we & ~is_word;
  assign sh        = {a[1:0], 3'b000};
  assign shifted   = dm_rd >> sh;
  assign byte8     = shifted[7:0];
  assign half16    = a[1] ? dm_rd[31:16] : dm_rd[15:0];
  assign load_val  = is_word ? dm_rd :
                     is_half ? {{16{r_sext & half16[15]}}, half16} :
                               {{24{r_sext & byte8[7]}}, byte8};
  assign mask      = is_half ? (a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : (32'h0000_00FF << sh);
  assign ins       = is_half ? {r_wdata[15:0], r_wdata[15:0]} : ({24'h0, r_wdata[7:0]} << sh);
  assign merged    = (dm_rd & ~mask) | (ins & mask);
  assign ready     = state == IDLE;
  assign dm_addr   = a;
  assign dm_pc     = r_pc;
  // Next-state and memory-side decode; dm_we depends on state so it drops with reset.
  always_comb begin
    state_nx = state;
    dm_we    = 1'b0;
    dm_wd    = r_wdata;
    fin      = 1'b0;
    case (state)
      IDLE:    state_nx = (accept & ~mis) ? ACCESS : IDLE;
      ACCESS: begin
        state_nx = sub_store ? WRITE : IDLE;
        dm_we    = r_we & is_word;
        fin      = ~sub_store;
      end
      WRITE: begin
        state_nx = IDLE;
        dm_we    = 1'b1;
        dm_wd    = merge;
        fin      = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  // State register.
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  // Request registers, captured only on acceptance.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= 2'd0;
      a       <= 32'h0;
      r_wdata <= 32'h0;
      r_pc    <= 32'h0;
    end else if (accept) begin
      r_we    <= we;
      r_sext  <= sext;
      r_size  <= size;
      a       <= a_in;
      r_wdata <= wdata;
      r_pc    <= pc;
    end
  // Merge register holds the read-modified word between the read and write cycles.
  always_ff @(posedge clk or negedge reset)
    if (!reset)                              merge <= 32'h0;
    else if (state == ACCESS && sub_store)   merge <= merged;
  // Completion outputs: done/err pulse for one cycle, rdata holds until the next completion.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= INIT_RDATA;
    end else begin
      done  <= fin | (accept & mis);
      err   <= accept & mis;
      rdata <= (accept & mis) ? 32'h0 : (state == ACCESS && !r_we) ? load_val : rdata;
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench for mem_access_ctrl with a word-addressed memory model.
module tb_mem_access_ctrl;
  logic        clk = 1'b0, reset = 1'b0, req = 1'b0, we = 1'b0, sext = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'h0, wdata = 32'h0, pc = 32'h0;
  logic        ready, done, err, dm_we;
  logic [31:0] rdata, dm_addr, dm_wd, dm_pc, dm_rd;
  logic [31:0] mem [0:63];
  int checks = 0, errors = 0;
  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .pc(pc), .ready(ready), .done(done), .rdata(rdata),
    .err(err), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc(dm_pc), .dm_rd(dm_rd)
  );
  always #5 clk = ~clk;
  assign dm_rd = mem[dm_addr[7:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[7:2]] <= dm_wd;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic w, input logic [1:0] s, input logic sx, input logic [31:0] ad, input logic [31:0] wd);
    @(negedge clk);
    req = 1'b1; we = w; size = s; sext = sx; addr = ad; wdata = wd; pc = ad + 32'h1000;
    @(posedge clk);
    #1 req = 1'b0;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input string tag, input logic [1:0] s, input logic sx, input logic [31:0] ad, input logic [31:0] exp);
    issue(1'b0, s, sx, ad, 32'h0);
    step;
    check({tag, "_done"}, {31'h0, done}, 32'h1);
    check(tag, rdata, exp);
  endtask
  initial begin
    #12;
    check("rst_ready", {31'h0, ready}, 32'h1);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_dm_we", {31'h0, dm_we}, 32'h0);
    @(negedge clk) reset = 1'b1;
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_dm_we", {31'h0, dm_we}, 32'h1);
    check("sw_dm_wd", dm_wd, 32'hDEADBEEF);
    check("sw_dm_addr", dm_addr, 32'h10);
    check("sw_dm_pc", dm_pc, 32'h1010);
    check("sw_ready", {31'h0, ready}, 32'h0);
    step;
    check("sw_done", {31'h0, done}, 32'h1);
    check("sw_ready2", {31'h0, ready}, 32'h1);
    check("sw_dm_we_off", {31'h0, dm_we}, 32'h0);
    step;
    check("sw_done_pulse", {31'h0, done}, 32'h0);
    load("lw_10", 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    step;
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h80F07F01);
    step;
    issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA);
    check("sb_c1_we", {31'h0, dm_we}, 32'h0);
    check("sb_c1_done", {31'h0, done}, 32'h0);
    step;
    check("sb_c2_we", {31'h0, dm_we}, 32'h1);
    check("sb_c2_wd", dm_wd, 32'h11AA3344);
    check("sb_c2_done", {31'h0, done}, 32'h0);
    step;
    check("sb_c3_done", {31'h0, done}, 32'h1);
    check("sb_mem", mem[4], 32'h11AA3344);
    load("lh_22_s", 2'd1, 1'b1, 32'h22, 32'hFFFF80F0);
    load("lhu_22", 2'd1, 1'b0, 32'h22, 32'h000080F0);
    load("lb_21_s", 2'd0, 1'b1, 32'h21, 32'h0000007F);
    load("lbu_20", 2'd0, 1'b0, 32'h20, 32'h00000001);
    load("lb_23_s", 2'd0, 1'b1, 32'h23, 32'hFFFFFF80);
    load("lh_20_s", 2'd1, 1'b1, 32'h20, 32'h00007F01);
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF1234);
    step;
    check("sh_c2_wd", dm_wd, 32'h12347F01);
    step;
    check("sh_mem", mem[8], 32'h12347F01);
    issue(1'b1, 2'd0, 1'b0, 32'h20, 32'h000000CD);
    step;
    step;
    check("sb0_mem", mem[8], 32'h12347FCD);
    issue(1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
`ifdef MAC_ALIGN_CHECK_EN
    check("mis_done", {31'h0, done}, 32'h1);
    check("mis_err", {31'h0, err}, 32'h1);
    check("mis_rdata", rdata, 32'h0);
    check("mis_dm_we", {31'h0, dm_we}, 32'h0);
    check("mis_ready", {31'h0, ready}, 32'h1);
    step;
    check("mis_done_pulse", {31'h0, done}, 32'h0);
    check("mis_err_pulse", {31'h0, err}, 32'h0);
`else
    check("mis_c1_done", {31'h0, done}, 32'h0);
    check("mis_dm_addr", dm_addr, 32'h10);
    step;
    check("mis_done", {31'h0, done}, 32'h1);
    check("mis_err", {31'h0, err}, 32'h0);
    check("mis_rdata", rdata, 32'h11AA3344);
`endif
    issue(1'b1, 2'd0, 1'b0, 32'h10, 32'h00000055);
    step;
    check("rmw_c2_we", {31'h0, dm_we}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_we", {31'h0, dm_we}, 32'h0);
    check("rst_mid_done", {31'h0, done}, 32'h0);
    check("rst_mid_ready", {31'h0, ready}, 32'h1);
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1;
    check("rst_mem", mem[4], 32'h11AA3344);
    check("rst_ready_after", {31'h0, ready}, 32'h1);
    check("rst_rdata_after", rdata, 32'h0);
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h20;
    step;
    check("b2b_c1_done", {31'h0, done}, 32'h0);
    check("b2b_c1_ready", {31'h0, ready}, 32'h0);
    addr = 32'h10;
    step;
    check("b2b_c2_done", {31'h0, done}, 32'h1);
    check("b2b_c2_rdata", rdata, 32'h12347FCD);
    check("b2b_c2_ready", {31'h0, ready}, 32'h1);
    step;
    req = 1'b0;
    check("b2b_c3_done", {31'h0, done}, 32'h0);
    check("b2b_c3_addr", dm_addr, 32'h10);
    step;
    check("b2b_c4_done", {31'h0, done}, 32'h1);
    check("b2b_c4_rdata", rdata, 32'h11AA3344);
    step;
    check("b2b_c5_done", {31'h0, done}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
